// File: rtl/dds_sweep_pkg.sv
// rtl/dds_sweep_pkg.sv - shared constants for the DDS frequency-sweep controller
package dds_sweep_pkg;

  localparam int TW_W_DEF    = 16;
  localparam int DWELL_W_DEF = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;

  localparam logic [2:0] ADDR_START_LO = 3'd0;
  localparam logic [2:0] ADDR_START_HI = 3'd1;
  localparam logic [2:0] ADDR_STEP_LO  = 3'd2;
  localparam logic [2:0] ADDR_STEP_HI  = 3'd3;
  localparam logic [2:0] ADDR_END_LO   = 3'd4;
  localparam logic [2:0] ADDR_END_HI   = 3'd5;
  localparam logic [2:0] ADDR_DWELL    = 3'd6;
  localparam logic [2:0] ADDR_CTRL     = 3'd7;

  localparam int CTRL_LOOP = 0;
  localparam int CTRL_TRI  = 1;

endpackage

// File: rtl/dds_sweep_if.sv
// rtl/dds_sweep_if.sv - config/control/output bundle between pin decode and sweep controller
interface dds_sweep_if #(
  parameter int TW_W = 16
) ();
  logic            cfg_we;
  logic [2:0]      cfg_addr;
  logic [7:0]      cfg_data;
  logic            start;
  logic            stop;
  logic [TW_W-1:0] tuning_word;
  logic            busy;
  logic            done;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, stop,
    input  tuning_word, busy, done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, stop,
    output tuning_word, busy, done
  );
endinterface

// File: rtl/dds_sweep_dwell_timer.sv
// rtl/dds_sweep_dwell_timer.sv - dwell down-counter issuing one update tick every reload+1 cycles
module dds_sweep_dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic [DWELL_W-1:0] i_clear_val,
  input  logic [DWELL_W-1:0] i_reload_val,
  input  logic               i_en,
  output logic               o_tick
);
  logic [DWELL_W-1:0] r_cnt;

  assign o_tick = i_en & ~i_clear & (r_cnt == '0);

  // Count down while sweeping; restart from the freshly latched dwell on start/stop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= i_clear_val;
    end else if (i_en) begin
      if (r_cnt == '0) r_cnt <= i_reload_val;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - frequency-sweep tuning-word generator feeding the DDS phase accumulator
module dds_sweep_ctrl
  import dds_sweep_pkg::*;
#(
  parameter int TW_W    = TW_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  dds_sweep_if.slave bus
);
  logic [15:0]        r_sh_start, r_sh_step, r_sh_end;
  logic [7:0]         r_sh_dwell;
  logic [1:0]         r_sh_ctrl;

  logic [TW_W-1:0]    r_start, r_step, r_end;
  logic [DWELL_W-1:0] r_dwell;
  logic [1:0]         r_ctrl;

  logic [1:0]         r_state;
  logic [TW_W-1:0]    r_tw;
  logic               r_done, r_busy, r_wrap;

  logic [1:0]         w_state_nxt;
  logic [TW_W-1:0]    w_tw_nxt;
  logic               w_done_nxt, w_wrap_nxt;
  logic               w_accept, w_tick;
  logic [TW_W:0]      w_up, w_dn;
  logic               w_up_end, w_dn_end;

  assign w_accept = bus.start & ~bus.stop;
  assign w_up     = {1'b0, r_tw} + {1'b0, r_step};
  assign w_dn     = {1'b0, r_tw} - {1'b0, r_step};
  assign w_up_end = w_up[TW_W] | (w_up[TW_W-1:0] >= r_end);
  assign w_dn_end = w_dn[TW_W] | (w_dn[TW_W-1:0] <= r_start);

  assign bus.tuning_word = r_tw;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

  dds_sweep_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (bus.start | bus.stop),
    .i_clear_val  (DWELL_W'(r_sh_dwell)),
    .i_reload_val (r_dwell),
    .i_en         (r_busy),
    .o_tick       (w_tick)
  );

  // Byte-wide writes into the shadow register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_start <= '0;
      r_sh_step  <= '0;
      r_sh_end   <= '0;
      r_sh_dwell <= '0;
      r_sh_ctrl  <= '0;
    end else if (bus.cfg_we) begin
      case (bus.cfg_addr)
        ADDR_START_LO: r_sh_start[7:0]  <= bus.cfg_data;
        ADDR_START_HI: r_sh_start[15:8] <= bus.cfg_data;
        ADDR_STEP_LO:  r_sh_step[7:0]   <= bus.cfg_data;
        ADDR_STEP_HI:  r_sh_step[15:8]  <= bus.cfg_data;
        ADDR_END_LO:   r_sh_end[7:0]    <= bus.cfg_data;
        ADDR_END_HI:   r_sh_end[15:8]   <= bus.cfg_data;
        ADDR_DWELL:    r_sh_dwell       <= bus.cfg_data;
        default:       r_sh_ctrl        <= bus.cfg_data[1:0];
      endcase
    end
  end

  // Snapshot the shadow config into the active set when a sweep is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start <= '0;
      r_step  <= '0;
      r_end   <= '0;
      r_dwell <= '0;
      r_ctrl  <= '0;
    end else if (w_accept) begin
      r_start <= TW_W'(r_sh_start);
      r_step  <= TW_W'(r_sh_step);
      r_end   <= TW_W'(r_sh_end);
      r_dwell <= DWELL_W'(r_sh_dwell);
      r_ctrl  <= r_sh_ctrl;
    end
  end

  // Next-state, next-word and end-event decode; stop beats start, start beats a tick
  always_comb begin
    w_state_nxt = r_state;
    w_tw_nxt    = r_tw;
    w_done_nxt  = 1'b0;
    w_wrap_nxt  = r_wrap;
    if (bus.stop) begin
      w_state_nxt = S_IDLE;
      w_wrap_nxt  = 1'b0;
    end else if (bus.start) begin
      w_state_nxt = S_UP;
      w_tw_nxt    = TW_W'(r_sh_start);
      w_wrap_nxt  = 1'b0;
    end else if (w_tick) begin
      case (r_state)
        S_UP: begin
          if (r_wrap) begin
            w_tw_nxt   = r_start;
            w_wrap_nxt = 1'b0;
          end else if (w_up_end) begin
            w_tw_nxt = r_end;
            if (r_ctrl[CTRL_TRI]) begin
              w_state_nxt = S_DOWN;
            end else begin
              w_done_nxt = 1'b1;
              if (r_ctrl[CTRL_LOOP]) w_wrap_nxt  = 1'b1;
              else                   w_state_nxt = S_IDLE;
            end
          end else begin
            w_tw_nxt = w_up[TW_W-1:0];
          end
        end
        S_DOWN: begin
          if (w_dn_end) begin
            w_tw_nxt    = r_start;
            w_done_nxt  = 1'b1;
            w_state_nxt = r_ctrl[CTRL_LOOP] ? S_UP : S_IDLE;
          end else begin
            w_tw_nxt = w_dn[TW_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // FSM and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tw    <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tw    <= w_tw_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_wrap  <= w_wrap_nxt;
    end
  end
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - self-checking bench for dds_sweep_ctrl
module tb_dds_sweep_ctrl;
  import dds_sweep_pkg::*;

  typedef struct {
    logic [15:0] st;
    logic [15:0] sp;
    logic [15:0] en;
    logic [7:0]  dw;
    logic [1:0]  ctrl;
    int          n;
  } vec_t;

  typedef struct {
    logic [15:0] tw;
    logic        busy;
    logic        done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  vec_t vecs[8];
  vec_t v0;

  dds_sweep_if #(.TW_W(16)) bus ();

  dds_sweep_ctrl #(.TW_W(16), .DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  task automatic program_cfg(input vec_t v);
    wr(ADDR_START_LO, v.st[7:0]);
    wr(ADDR_START_HI, v.st[15:8]);
    wr(ADDR_STEP_LO,  v.sp[7:0]);
    wr(ADDR_STEP_HI,  v.sp[15:8]);
    wr(ADDR_END_LO,   v.en[7:0]);
    wr(ADDR_END_HI,   v.en[15:8]);
    wr(ADDR_DWELL,    v.dw);
    wr(ADDR_CTRL,     {6'd0, v.ctrl});
  endtask

  // Slot-based reference: one entry per cycle, entry 0 is the cycle right after start.
  task automatic model(input vec_t v);
    int   tw, nx;
    bit   busy, dn, wrap, done;
    exp_t e;
    tw = int'(v.st); busy = 1'b1; dn = 1'b0; wrap = 1'b0;
    for (int c = 0; c < v.n; c++) begin
      done = 1'b0;
      if (c > 0 && busy && (c % (int'(v.dw) + 1)) == 0) begin
        if (!dn) begin
          if (wrap) begin
            tw = int'(v.st); wrap = 1'b0;
          end else begin
            nx = tw + int'(v.sp);
            if (nx >= int'(v.en)) begin
              tw = int'(v.en);
              if (v.ctrl[1]) dn = 1'b1;
              else begin
                done = 1'b1;
                if (v.ctrl[0]) wrap = 1'b1;
                else           busy = 1'b0;
              end
            end else tw = nx;
          end
        end else begin
          nx = tw - int'(v.sp);
          if (nx <= int'(v.st)) begin
            tw = int'(v.st); done = 1'b1; dn = 1'b0;
            if (!v.ctrl[0]) busy = 1'b0;
          end else tw = nx;
        end
      end
      e.tw = 16'(tw); e.busy = busy; e.done = done;
      exp_q.push_back(e);
    end
  endtask

  task automatic run(input string name, input vec_t v);
    exp_t e;
    model(v);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < v.n; i++) begin
      e = exp_q.pop_front();
      check(name, {14'd0, bus.tuning_word, bus.busy, bus.done}, {14'd0, e.tw, e.busy, e.done});
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0] = '{st:16'h0100, sp:16'h0040, en:16'h0200, dw:8'd0, ctrl:2'b00, n:8};
    vecs[1] = '{st:16'h0100, sp:16'h0040, en:16'h0200, dw:8'd3, ctrl:2'b00, n:22};
    vecs[2] = '{st:16'h0010, sp:16'h0008, en:16'h0020, dw:8'd0, ctrl:2'b11, n:12};
    vecs[3] = '{st:16'hFFF0, sp:16'h0020, en:16'hFFFF, dw:8'd0, ctrl:2'b00, n:4};
    vecs[4] = '{st:16'h0000, sp:16'h0040, en:16'h0100, dw:8'd1, ctrl:2'b01, n:20};
    vecs[5] = '{st:16'h0005, sp:16'h0000, en:16'h0010, dw:8'd0, ctrl:2'b00, n:6};
    vecs[6] = '{st:16'h0300, sp:16'h0001, en:16'h0200, dw:8'd2, ctrl:2'b00, n:6};
    vecs[7] = '{st:16'h0010, sp:16'h0008, en:16'h0020, dw:8'd1, ctrl:2'b10, n:14};
    v0      = '{st:16'h0000, sp:16'h0000, en:16'h0000, dw:8'd0, ctrl:2'b00, n:4};

    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.start = 1'b0; bus.stop = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_tw",   {16'd0, bus.tuning_word}, 32'h0);
    check("reset_busy", {31'd0, bus.busy}, 32'h0);
    check("reset_done", {31'd0, bus.done}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      program_cfg(vecs[i]);
      run($sformatf("vec%0d", i), vecs[i]);
    end

    // stop mid-dwell freezes the word
    program_cfg(vecs[1]);
    vecs[1].n = 6;
    run("pre_stop", vecs[1]);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stop_hold", {14'd0, bus.tuning_word, bus.busy, bus.done}, {14'd0, 16'h0140, 1'b0, 1'b0});
      @(negedge clk);
    end

    // start and stop together: stop wins
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    check("start_stop", {14'd0, bus.tuning_word, bus.busy, bus.done}, {14'd0, 16'h0140, 1'b0, 1'b0});
    @(negedge clk);
    check("start_stop_hold", {14'd0, bus.tuning_word, bus.busy, bus.done}, {14'd0, 16'h0140, 1'b0, 1'b0});

    // config write coincident with start is not captured by that start
    bus.start = 1'b1; bus.cfg_we = 1'b1; bus.cfg_addr = ADDR_START_HI; bus.cfg_data = 8'h05;
    @(negedge clk);
    bus.start = 1'b0; bus.cfg_we = 1'b0;
    check("same_cycle_cfg_old", {15'd0, bus.tuning_word, bus.busy}, {15'd0, 16'h0100, 1'b1});
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("same_cycle_cfg_new", {15'd0, bus.tuning_word, bus.busy}, {15'd0, 16'h0500, 1'b1});

    // asynchronous reset mid-sweep
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {14'd0, bus.tuning_word, bus.busy, bus.done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("post_rst", v0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep controller that generates the 16-bit tuning word feeding the DDS phase accumulator (`top.tuningW`). Configuration (start, step, end, dwell, mode) is loaded through a byte-wide write port into shadow registers and copied to active registers on `start`. A small FSM then steps the tuning word up, and optionally back down, at a programmable rate. Sits between the chip-level pin decode in the TinyTapeout wrapper and the DDS core.

## Interface
- `TW_W`, 16, tuning-word width; must match the DDS `tune` parameter.
- `DWELL_W`, 8, dwell counter width.
- `clk` input 1: single system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cfg_we` input 1: config byte write strobe, one write per cycle.
- `cfg_addr` input 3: register select. 0/1 START lo/hi; 2/3 STEP lo/hi; 4/5 END lo/hi; 6 DWELL; 7 CTRL (bit0 LOOP, bit1 TRI).
- `cfg_data` input 8: write data.
- `start` input 1: level sampled each cycle; latches the shadow registers and begins a sweep.
- `stop` input 1: aborts the sweep and holds the current word.
- `tuning_word` output TW_W: registered word driven to the DDS.
- `busy` output 1: high while the FSM is in UP or DOWN.
- `done` output 1: one-cycle pulse when an end point is reached.

## Operation
- Shadow regs are written by `cfg_we`. The active regs (A_START, A_STEP, A_END, A_DWELL, A_CTRL) are copied from shadow only when `start` is accepted.
- States:
  - IDLE: `tuning_word` holds its value.
  - UP: word increases by A_STEP.
  - DOWN: word decreases by A_STEP (TRI mode only).
- Accepting `start` (in any state, `stop` low):
  - load the active regs;
  - set tuning_word=A_START;
  - clear the dwell counter;
  - go to UP.
- `stop` in any state: go to IDLE, hold the word, no `done`. When `start` and `stop` are both high, `stop` wins.
- Dwell: the word updates once every A_DWELL+1 cycles. A_DWELL=0 means an update every cycle.
- UP update:
  - next = tw + A_STEP, computed 17 bits wide.
  - If carry is set or next ≥ A_END, then tw=A_END and an end event occurs; otherwise tw=next.
- UP end event:
  - TRI=1: go to DOWN; `done` pulses only if LOOP=0 and the DOWN leg also completes, i.e. no pulse here.
  - TRI=0, LOOP=1: tw=A_START on the next update slot and stay in UP; `done` pulses.
  - TRI=0, LOOP=0: go to IDLE holding A_END; `done` pulses.
- DOWN update:
  - next = tw − A_STEP with borrow.
  - If borrow is set or next ≤ A_START, then tw=A_START; otherwise tw=next.
- DOWN end event:
  - LOOP=1: go to UP; `done` pulses.
  - LOOP=0: go to IDLE holding A_START; `done` pulses.
- A_STEP=0 with A_START<A_END: the word holds A_START and `busy` stays high until `stop`.
- A_START ≥ A_END: the first UP update clamps to A_END and takes the end event.
- The LOOP sawtooth wrap (A_END→A_START) consumes one full dwell slot.

## Timing
- Reset values:
  - tuning_word=0, busy=0, done=0, state IDLE;
  - all shadow and active regs 0.
- `start` sampled at edge k: tuning_word=A_START and busy=1 after edge k, latency 1.
- First step lands A_DWELL+1 edges after edge k.
- `done` is asserted in the same cycle the clamped end value first appears on `tuning_word`. `busy` falls in that same cycle on a one-shot finish.
- A `cfg_we` in the same cycle as `start` is not captured by that start; it becomes visible to the next one.
- `stop` at edge k: busy=0 after edge k and the word is frozen, including mid-dwell.
- `rst_n` low mid-sweep forces all outputs to reset values immediately, without waiting for a clock edge. Operation resumes on the first edge after release.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `dds_sweep_pkg` holds:
  - the state encoding (IDLE/UP/DOWN);
  - the `cfg_addr` constants;
  - the CTRL bit indices;
  - default `TW_W`/`DWELL_W`.
- Sub-module `dds_sweep_dwell_timer`:
  - a down-counter loaded with A_DWELL;
  - emits `tick` when it reaches 0 and reloads;
  - has a synchronous clear on start/stop.
- The top module holds the shadow and active regs, the FSM and the clamp arithmetic.

## Test plan
- Reset, then START=0x0100, STEP=0x0040, END=0x0200, DWELL=0, CTRL=0, pulse start:
  - tuning_word sequence 0x0100, 0x0140 … 0x0200;
  - `done` pulses with 0x0200;
  - busy drops and the word holds 0x0200.
- Same config with DWELL=3: each value holds exactly 4 cycles.
- CTRL=TRI|LOOP, START=0x10, STEP=0x08, END=0x20:
  - word sequence 10, 18, 20, 18, 10, 18 …;
  - `done` at each return to 0x10.
- Overflow: START=0xFFF0, STEP=0x0020, END=0xFFFF: the first step clamps to 0xFFFF with no wrap, and `done` pulses.
- Start and stop edge cases:
  - `start` and `stop` in the same cycle: stays IDLE, the word is unchanged.
  - `cfg_we` START=0x0500 in the same cycle as `start`: the sweep uses the old START.
- Assert `rst_n` mid-sweep: tuning_word=0 and busy=0 before the next edge. After release, a new `start` sweeps from shadow values of 0.
